// File: rtl/mem_wb_stage.sv
// mem_wb_stage: load alignment, miss stall/bubble control and writeback register with debug counters.
module mem_wb_stage #(
   parameter int MISS_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        mem_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        is_LB_SB,
   input  logic        mem_to_reg,
   input  logic        reg_write_in,
   input  logic [4:0]  rd_in,
   input  logic [31:0] alu_result,
   input  logic        hit,
   input  logic [31:0] cache_data_out,
   output logic        stall,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [31:0] access_count,
   output logic [31:0] miss_count,
   output logic        miss_timeout
);
   typedef enum logic {RUN, MISS} state_t;
   localparam logic [15:0] TO_M1 = 16'(MISS_TIMEOUT - 1);
   state_t      state, state_nx;
   logic        mem_op, miss_event, accept;
   logic [7:0]  lb_byte;
   logic [31:0] aligned, next_data;
   logic [15:0] miss_cyc;
   assign mem_op = mem_valid & (mem_read | mem_write);
   assign stall  = mem_op & ~hit;
   assign accept = ~stall & mem_valid;
   // byte 0 lives in the most significant lane
   assign lb_byte = alu_result[1:0] == 2'd0 ? cache_data_out[31:24] :
                    alu_result[1:0] == 2'd1 ? cache_data_out[23:16] :
                    alu_result[1:0] == 2'd2 ? cache_data_out[15:8]  : cache_data_out[7:0];
   assign aligned   = is_LB_SB ? {{24{lb_byte[7]}}, lb_byte} : cache_data_out;
   assign next_data = mem_to_reg ? aligned : alu_result;
   always_comb begin
      state_nx   = state;
      miss_event = 1'b0;
      state_nx   = stall ? MISS : RUN;
      miss_event = (state == RUN) & stall;
   end
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state        <= RUN;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         access_count <= '0;
         miss_count   <= '0;
         miss_cyc     <= '0;
         miss_timeout <= 1'b0;
      end else begin
         state        <= state_nx;
         wb_reg_write <= accept & reg_write_in;
         if (accept) begin
            wb_rd   <= rd_in;
            wb_data <= next_data;
         end
         miss_cyc <= !stall ? '0 : (miss_cyc == 16'hFFFF ? miss_cyc : miss_cyc + 16'd1);
         if (stall && miss_cyc == TO_M1) miss_timeout <= 1'b1;
         if (mem_op && hit && access_count != '1) access_count <= access_count + 32'd1;
         if (miss_event && miss_count != '1) miss_count <= miss_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random stimulus checked against a behavioural model of the stage.
module tb_mem_wb_stage;
   localparam int MT = 4;
   logic        clk = 1'b0, rst_b = 1'b0;
   logic        mem_valid, mem_read, mem_write, is_LB_SB, mem_to_reg, reg_write_in, hit;
   logic [4:0]  rd_in;
   logic [31:0] alu_result, cache_data_out;
   logic        stall, wb_reg_write, miss_timeout;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, access_count, miss_count;
   int passed = 0, total = 0;
   logic        e_we = 0, e_to = 0, prev_stall = 0;
   logic [4:0]  e_rd = 0;
   logic [31:0] e_data = 0, e_acc = 0, e_miss = 0;
   int          run_len = 0;

   mem_wb_stage #(.MISS_TIMEOUT(MT)) dut (
      .clk(clk), .rst_b(rst_b), .mem_valid(mem_valid), .mem_read(mem_read),
      .mem_write(mem_write), .is_LB_SB(is_LB_SB), .mem_to_reg(mem_to_reg),
      .reg_write_in(reg_write_in), .rd_in(rd_in), .alu_result(alu_result), .hit(hit),
      .cache_data_out(cache_data_out), .stall(stall), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .access_count(access_count),
      .miss_count(miss_count), .miss_timeout(miss_timeout));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic exp_stall();
      return mem_valid && (mem_read || mem_write) && !hit;
   endfunction

   function automatic logic [31:0] exp_load();
      int b;
      if (!is_LB_SB) return cache_data_out;
      b = int'((cache_data_out >> (8 * (3 - int'(alu_result[1:0])))) & 32'hFF);
      return 32'(b >= 128 ? b - 256 : b);
   endfunction

   task automatic drive(input logic v, r, w, lb, m2r, rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic h, input logic [31:0] cd);
      mem_valid = v; mem_read = r; mem_write = w; is_LB_SB = lb; mem_to_reg = m2r;
      reg_write_in = rw; rd_in = rd; alu_result = alu; hit = h; cache_data_out = cd;
   endtask

   task automatic model_edge();
      logic s;
      s = exp_stall();
      if (!rst_b) begin
         e_we = 0; e_rd = 0; e_data = 0; e_acc = 0; e_miss = 0; e_to = 0;
         run_len = 0; prev_stall = 0;
         return;
      end
      if (s) begin
         e_we = 0;
         if (!prev_stall && e_miss != 32'hFFFFFFFF) e_miss++;
         run_len++;
         if (run_len >= MT) e_to = 1;
      end else begin
         run_len = 0;
         e_we = mem_valid && reg_write_in;
         if (mem_valid) begin
            e_rd = rd_in;
            e_data = mem_to_reg ? exp_load() : alu_result;
         end
         if (mem_valid && (mem_read || mem_write) && e_acc != 32'hFFFFFFFF) e_acc++;
      end
      prev_stall = s;
   endtask

   task automatic tick();
      #1 chk("stall", 32'(stall), 32'(exp_stall()));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("wb_reg_write", 32'(wb_reg_write), 32'(e_we));
      chk("wb_rd", 32'(wb_rd), 32'(e_rd));
      chk("wb_data", wb_data, e_data);
      chk("access_count", access_count, e_acc);
      chk("miss_count", miss_count, e_miss);
      chk("miss_timeout", 32'(miss_timeout), 32'(e_to));
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick(); tick();
      chk("reset_wb_data", wb_data, 32'h0);
      rst_b = 1;
      drive(1, 1, 0, 0, 1, 1, 5, 32'h10, 1, 32'h12345678);
      tick();
      chk("lw_data", wb_data, 32'h12345678);
      chk("lw_acc", access_count, 32'd1);
      drive(1, 1, 0, 1, 1, 1, 5, 32'h12, 1, 32'h12345678);
      tick();
      chk("lb_pos", wb_data, 32'h00000056);
      cache_data_out = 32'h12349A78;
      tick();
      chk("lb_neg", wb_data, 32'hFFFFFF9A);
      drive(1, 1, 0, 0, 1, 1, 9, 32'h20, 0, 32'hCAFEF00D);
      repeat (3) begin tick(); chk("miss_bubble", 32'(wb_reg_write), 32'd0); end
      hit = 1;
      tick();
      chk("miss_data", wb_data, 32'hCAFEF00D);
      chk("miss_cnt", miss_count, 32'd1);
      drive(1, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
      tick();
      chk("alu_data", wb_data, 32'hDEADBEEF);
      chk("alu_cnt", miss_count, 32'd1);
      drive(0, 1, 1, 0, 0, 0, 3, 32'h4, 0, 0);
      tick();
      chk("bubble_invalid", 32'(wb_reg_write), 32'd0);
      drive(1, 0, 1, 1, 0, 0, 3, 32'h40, 0, 32'h11223344);
      repeat (3) tick();
      chk("to_before", 32'(miss_timeout), 32'd0);
      tick();
      chk("to_set", 32'(miss_timeout), 32'd1);
      hit = 1;
      tick();
      chk("to_sticky", 32'(miss_timeout), 32'd1);
      chk("store_no_write", 32'(wb_reg_write), 32'd0);
      hit = 0;
      tick(); tick();
      rst_b = 0;
      tick();
      chk("rst_miss", miss_count, 32'd0);
      chk("rst_to", 32'(miss_timeout), 32'd0);
      rst_b = 1;
      mem_valid = 0;
      tick();
      chk("rst_stall", 32'(stall), 32'd0);
      for (int i = 0; i < 400; i++) begin
         rst_b = ($urandom_range(0, 59) != 0);
         drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 5'($urandom), $urandom,
               $urandom_range(0, 9) < 6, $urandom);
         tick();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
